// File: rtl/decoder_scan_if.sv
// Bundle of the control inputs and decoded outputs of decoder_scan.
// The master side (controller or testbench) drives the mode controls;
// the slave side (the decoder) returns the registered select lines and status.
interface decoder_scan_if #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel_in;
    logic             load;
    logic             start;
    logic [OUT_W-1:0] outsig;
    logic [SEL_W-1:0] cur_sel;
    logic             step;
    logic             busy;
    logic             done;
    logic             sel_err;

    modport master (
        output en, mode, sel_in, load, start,
        input  outsig, cur_sel, step, busy, done, sel_err
    );

    modport slave (
        input  en, mode, sel_in, load, start,
        output outsig, cur_sel, step, busy, done, sel_err
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a built-in scan/sweep sequencer for
// multiplexed displays. DIRECT decodes sel_in, SCAN_UP/SCAN_DN step the
// active line at a prescaled rate, SWEEP runs a single 0..OUT_W-1 pass.
// The index never leaves 0..OUT_W-1, so wrap arithmetic is modulo OUT_W.
module decoder_scan #(
    parameter int SEL_W      = 4,
    parameter int OUT_W      = 16,
    parameter int PRESCALE   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_scan_if.slave bus
);

    localparam int               PW       = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]    PS_TERM  = PW'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W:0]   OUT_LIM  = (SEL_W + 1)'(OUT_W);
    localparam logic [OUT_W-1:0] BLANK    = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DN     = 2'b10;
    localparam logic [1:0] MODE_SWEEP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_SWEEP  = 2'd3
    } state_t;

    // One-hot decode of an index, with output polarity applied
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (idx == SEL_W'(i));
        end
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    // Next index upward, wrapping at the last real output line
    function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] idx);
        return (idx >= IDX_LAST) ? {SEL_W{1'b0}} : idx + SEL_W'(1);
    endfunction

    // Next index downward, wrapping from 0 to the last real output line
    function automatic logic [SEL_W-1:0] idx_dec(input logic [SEL_W-1:0] idx);
        return (idx == {SEL_W{1'b0}}) ? IDX_LAST : idx - SEL_W'(1);
    endfunction

    state_t           state_q,   state_d;
    logic [1:0]       mode_q,    mode_d;
    logic [SEL_W-1:0] idx_q,     idx_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic [OUT_W-1:0] outsig_q,  outsig_d;
    logic             step_q,    step_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             sel_err_q, sel_err_d;

    logic             mode_chg_s;
    logic             in_range_s;
    logic             show_s;
    logic [SEL_W-1:0] load_idx_s;

    // Next-state logic: mode dispatch, prescaler, index stepping and sweep control
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        presc_d    = presc_q;
        step_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_err_d  = sel_err_q;
        show_s     = 1'b0;
        mode_chg_s = (bus.mode != mode_q);
        in_range_s = ({1'b0, bus.sel_in} < OUT_LIM);
        load_idx_s = in_range_s ? bus.sel_in : IDX_LAST;

        if (!bus.en) begin
            // frozen: counters, index and state hold, lines blanked
            show_s = 1'b0;
        end else begin
            mode_d    = bus.mode;
            sel_err_d = 1'b0;
            busy_d    = 1'b0;
            case (bus.mode)
                MODE_DIRECT: begin
                    state_d = ST_DIRECT;
                    presc_d = {PW{1'b0}};
                    if (in_range_s) begin
                        idx_d  = bus.sel_in;
                        show_s = 1'b1;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                MODE_UP, MODE_DN: begin
                    state_d = ST_SCAN;
                    show_s  = 1'b1;
                    if (bus.load) begin
                        idx_d   = load_idx_s;
                        presc_d = {PW{1'b0}};
                    end else if (mode_chg_s) begin
                        presc_d = {PW{1'b0}};
                    end else if (presc_q == PS_TERM) begin
                        presc_d = {PW{1'b0}};
                        idx_d   = (bus.mode == MODE_UP) ? idx_inc(idx_q) : idx_dec(idx_q);
                        step_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                MODE_SWEEP: begin
                    if (mode_chg_s) begin
                        // entering sweep mode never starts a pass in the same cycle
                        state_d = ST_IDLE;
                        presc_d = {PW{1'b0}};
                    end else if (state_q == ST_SWEEP) begin
                        if (presc_q == PS_TERM) begin
                            presc_d = {PW{1'b0}};
                            if (idx_q == IDX_LAST) begin
                                state_d = ST_IDLE;
                                idx_d   = {SEL_W{1'b0}};
                                done_d  = 1'b1;
                            end else begin
                                idx_d  = idx_inc(idx_q);
                                step_d = 1'b1;
                                busy_d = 1'b1;
                                show_s = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                            busy_d  = 1'b1;
                            show_s  = 1'b1;
                        end
                    end else if (bus.start) begin
                        state_d = ST_SWEEP;
                        idx_d   = {SEL_W{1'b0}};
                        presc_d = {PW{1'b0}};
                        busy_d  = 1'b1;
                        show_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        outsig_d = show_s ? decode(idx_d) : BLANK;
    end

    // State and output registers, cleared asynchronously to the all-inactive state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_DIRECT;
            idx_q     <= {SEL_W{1'b0}};
            presc_q   <= {PW{1'b0}};
            outsig_q  <= BLANK;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            presc_q   <= presc_d;
            outsig_q  <= outsig_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.outsig  = outsig_q;
    assign bus.cur_sel = idx_q;
    assign bus.step    = step_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan. Three instances share one stimulus
// stream: (OUT_W=10, PRESCALE=3), the same with active-low outputs, and
// (OUT_W=16, PRESCALE=1). A behavioural model predicts every output each
// cycle; a monitor compares after each rising edge. Directed checks cover
// the specific values of interest.
module tb_decoder_scan;

    typedef struct packed {
        logic [15:0] o;
        logic [3:0]  cs;
        logic        st;
        logic        bz;
        logic        dn;
        logic        er;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       en_v;
    logic [1:0] mode_v;
    logic [3:0] sel_in_v;
    logic       load_v;
    logic       start_v;

    int total = 0;
    int bad   = 0;

    decoder_scan_if #(.SEL_W(4), .OUT_W(10)) ifa ();
    decoder_scan_if #(.SEL_W(4), .OUT_W(10)) ifb ();
    decoder_scan_if #(.SEL_W(4), .OUT_W(16)) ifc ();

    assign ifa.en = en_v;  assign ifa.mode = mode_v;  assign ifa.sel_in = sel_in_v;
    assign ifa.load = load_v;  assign ifa.start = start_v;
    assign ifb.en = en_v;  assign ifb.mode = mode_v;  assign ifb.sel_in = sel_in_v;
    assign ifb.load = load_v;  assign ifb.start = start_v;
    assign ifc.en = en_v;  assign ifc.mode = mode_v;  assign ifc.sel_in = sel_in_v;
    assign ifc.load = load_v;  assign ifc.start = start_v;

    decoder_scan #(.SEL_W(4), .OUT_W(10), .PRESCALE(3), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    decoder_scan #(.SEL_W(4), .OUT_W(10), .PRESCALE(3), .ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    decoder_scan #(.SEL_W(4), .OUT_W(16), .PRESCALE(1), .ACTIVE_LOW(0)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int   cfg_ow [3] = '{10, 10, 16};
    int   cfg_ps [3] = '{3, 3, 1};
    int   cfg_al [3] = '{0, 1, 0};
    int   m_idx  [3];
    int   m_cnt  [3];
    int   m_t    [3];
    bit   m_run  [3];
    logic [1:0] m_pm [3];
    obs_t m_out  [3];
    obs_t exp_q  [$];

    // Predict the outputs after the coming rising edge for configuration k
    task automatic model_step(input int k);
        int ow, ps;
        obs_t e;
        logic [15:0] mask;
        bit chg, show;
        ow   = cfg_ow[k];
        ps   = cfg_ps[k];
        mask = 16'((32'd1 << ow) - 32'd1);
        e    = m_out[k];
        show = 1'b0;
        if (!rst_n) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_t[k] = 0; m_run[k] = 1'b0; m_pm[k] = 2'd0;
            e.st = 1'b0; e.dn = 1'b0; e.bz = 1'b0; e.er = 1'b0;
        end else if (!en_v) begin
            e.st = 1'b0; e.dn = 1'b0;
        end else begin
            chg = (mode_v != m_pm[k]);
            m_pm[k] = mode_v;
            e.st = 1'b0; e.dn = 1'b0; e.er = 1'b0;
            if (mode_v == 2'd0) begin
                m_cnt[k] = 0; m_run[k] = 1'b0;
                if (int'(sel_in_v) < ow) begin m_idx[k] = int'(sel_in_v); show = 1'b1; end
                else e.er = 1'b1;
            end else if (mode_v != 2'd3) begin
                m_run[k] = 1'b0; show = 1'b1;
                if (load_v) begin
                    m_idx[k] = (int'(sel_in_v) >= ow) ? ow - 1 : int'(sel_in_v);
                    m_cnt[k] = 0;
                end else if (chg) m_cnt[k] = 0;
                else if (m_cnt[k] == ps - 1) begin
                    m_cnt[k] = 0;
                    m_idx[k] = (m_idx[k] + ((mode_v == 2'd1) ? 1 : ow - 1)) % ow;
                    e.st = 1'b1;
                end else m_cnt[k]++;
            end else begin
                if (chg) begin
                    m_run[k] = 1'b0; m_cnt[k] = 0;
                end else if (m_run[k]) begin
                    m_t[k]++;
                    if (m_t[k] == ow * ps) begin
                        m_run[k] = 1'b0; e.dn = 1'b1; m_idx[k] = 0;
                    end else begin
                        show = 1'b1;
                        if (m_t[k] % ps == 0) e.st = 1'b1;
                        m_idx[k] = m_t[k] / ps;
                    end
                end else if (start_v) begin
                    m_run[k] = 1'b1; m_t[k] = 0; m_idx[k] = 0; show = 1'b1;
                end
            end
            e.bz = m_run[k];
        end
        e.cs = 4'(m_idx[k]);
        e.o  = show ? (16'd1 << m_idx[k]) : 16'd0;
        if (cfg_al[k] != 0) e.o = ~e.o & mask;
        m_out[k] = e;
        exp_q.push_back(e);
    endtask

    // Push predictions for the next edge, then advance to the falling edge
    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic obs_t get_obs(input int k);
        obs_t a;
        case (k)
            0: a = '{16'(ifa.outsig), ifa.cur_sel, ifa.step, ifa.busy, ifa.done, ifa.sel_err};
            1: a = '{16'(ifb.outsig), ifb.cur_sel, ifb.step, ifb.busy, ifb.done, ifb.sel_err};
            default: a = '{ifc.outsig, ifc.cur_sel, ifc.step, ifc.busy, ifc.done, ifc.sel_err};
        endcase
        return a;
    endfunction

    // Monitor: after each rising edge pop three predictions and compare
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() < 3) begin
                total++; bad++;
                $display("FAIL sb_empty: got %0d queued want 3", exp_q.size());
            end else begin
                for (int k = 0; k < 3; k++) begin
                    e = exp_q.pop_front();
                    a = get_obs(k);
                    total++;
                    if (a !== e) begin
                        bad++;
                        $display("FAIL sb_cfg%0d: got o=%h sel=%0d st=%b bz=%b dn=%b er=%b want o=%h sel=%0d st=%b bz=%b dn=%b er=%b (t=%0t)",
                                 k, a.o, a.cs, a.st, a.bz, a.dn, a.er, e.o, e.cs, e.st, e.bz, e.dn, e.er, $time);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int busy_n, done_n, steps_a;
        int seq_a [12] = '{8, 8, 8, 9, 9, 9, 0, 0, 0, 1, 1, 1};
        rst_n = 1'b0; en_v = 1'b1; mode_v = 2'd0; sel_in_v = 4'd0; load_v = 1'b0; start_v = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_outsig", int'(ifa.outsig), 0);
        chk("rst_outsig_al", int'(ifb.outsig), 10'h3FF);

        // DIRECT decode, out-of-range select, active-low polarity
        sel_in_v = 4'd5;  tick();
        chk("dir5_a", int'(ifa.outsig), 10'b0000100000);
        chk("dir5_b", int'(ifb.outsig), 10'b1111011111);
        sel_in_v = 4'd12; tick();
        chk("dir12_out", int'(ifa.outsig), 0);
        chk("dir12_err", int'(ifa.sel_err), 1);
        chk("dir12_c", int'(ifc.outsig), 16'h1000);
        sel_in_v = 4'd0;  tick();
        chk("dir0_al", int'(ifb.outsig), 10'b1111111110);

        // SCAN_UP from load 8, wrap 9 -> 0; fast instance wraps 15 -> 0
        mode_v = 2'd1; load_v = 1'b1; sel_in_v = 4'd8; tick();
        load_v = 1'b0;
        steps_a = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            chk("up_seq_a", int'(ifa.cur_sel), seq_a[i]);
            chk("up_seq_c", int'(ifc.cur_sel), (8 + i) % 16);
            steps_a += int'(ifa.step);
        end
        chk("up_steps", steps_a, 3);
        // next edge is terminal count: load must win with no step
        load_v = 1'b1; sel_in_v = 4'd4; tick(); load_v = 1'b0;
        chk("ld_tc_sel", int'(ifa.cur_sel), 4);
        chk("ld_tc_step", int'(ifa.step), 0);

        // SCAN_DN from 0 wraps to the last line
        mode_v = 2'd2; load_v = 1'b1; sel_in_v = 4'd0; tick(); load_v = 1'b0;
        tick(); tick(); tick();
        chk("dn_wrap", int'(ifa.cur_sel), 9);
        chk("dn_step", int'(ifa.step), 1);

        // freeze mid-step, then resume with the remaining count
        tick();
        en_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_out", int'(ifa.outsig), 0);
            chk("frz_sel", int'(ifa.cur_sel), 9);
        end
        en_v = 1'b1;
        tick(); chk("res_hold", int'(ifa.cur_sel), 9);
        tick(); chk("res_step", int'(ifa.cur_sel), 8);

        // SWEEP: full pass, second start ignored, done pulse with blank
        mode_v = 2'd3; tick();
        chk("swp_idle_busy", int'(ifa.busy), 0);
        chk("swp_idle_out", int'(ifa.outsig), 0);
        start_v = 1'b1; tick(); start_v = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 34; i++) begin
            if (ifa.busy) begin
                chk("swp_idx", int'(ifa.cur_sel), busy_n / 3);
                busy_n++;
            end
            if (ifa.done) begin
                done_n++;
                chk("swp_done_out", int'(ifa.outsig), 0);
                chk("swp_done_sel", int'(ifa.cur_sel), 0);
            end
            start_v = (i == 6);
            tick();
        end
        start_v = 1'b0;
        chk("swp_busy_cyc", busy_n, 30);
        chk("swp_done_cnt", done_n, 1);
        // abort mid-sweep by mode change
        start_v = 1'b1; tick(); start_v = 1'b0;
        repeat (10) tick();
        mode_v = 2'd1; tick();
        chk("abort_busy", int'(ifa.busy), 0);
        chk("abort_done", int'(ifa.done), 0);
        // start coincident with entering sweep mode is ignored
        mode_v = 2'd3; start_v = 1'b1; tick(); start_v = 1'b0;
        chk("start_chg", int'(ifa.busy), 0);

        // random DIRECT
        mode_v = 2'd0;
        for (int i = 0; i < 1000; i++) begin
            en_v     = ($urandom_range(0, 15) != 0);
            sel_in_v = 4'($urandom_range(0, 15));
            load_v   = 1'($urandom_range(0, 1));
            start_v  = 1'($urandom_range(0, 1));
            tick();
        end
        // random everything, mode held for random stretches
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) mode_v = 2'($urandom_range(0, 3));
            en_v     = ($urandom_range(0, 15) != 0);
            sel_in_v = 4'($urandom_range(0, 15));
            load_v   = ($urandom_range(0, 9) == 0);
            start_v  = ($urandom_range(0, 7) == 0);
            tick();
        end

        // asynchronous reset mid-SCAN, no clock edge needed
        en_v = 1'b1; start_v = 1'b0; mode_v = 2'd1; load_v = 1'b1; sel_in_v = 4'd5; tick();
        load_v = 1'b0; tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(ifa.outsig), 0);
        chk("arst_sel", int'(ifa.cur_sel), 0);
        chk("arst_busy", int'(ifa.busy), 0);
        chk("arst_out_al", int'(ifb.outsig), 10'h3FF);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_sel", int'(ifa.cur_sel), 0);
            chk("post_rst_busy", int'(ifa.busy), 0);
        end
        tick();
        chk("post_rst_step", int'(ifa.cur_sel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
